// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt/trap sequencer: synchronizes interrupt lines, drains the
// pipeline, performs trap entry, and sequences MRET return and WFI sleep/wake.
module irq_trap_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mie_mtie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_csr,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic        id_is_wfi,
    input  logic        wb_is_mret,
    input  logic        dm_stall,
    output logic        interrupt_stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        mepc_we,
    output logic [31:0] mepc_wdata,
    output logic        mcause_we,
    output logic [31:0] mcause_wdata,
    output logic        mstatus_trap,
    output logic        mstatus_mret,
    output logic        mip_meip,
    output logic        mip_mtip,
    output logic [1:0]  state_o
);

    localparam int unsigned CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] CNT_INIT  = CW'(DRAIN_CYCLES);
    localparam logic [31:0]   CAUSE_EXT = 32'h8000_000B;
    localparam logic [31:0]   CAUSE_TIM = 32'h8000_0007;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_TRAP  = 2'd2,
        S_SLEEP = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_ext_s1, r_ext_s2, r_tim_s1, r_tim_s2;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]   r_resume_pc, w_resume_nxt;
    logic [31:0]   r_cause, w_cause_nxt;
    logic          w_ext_pend, w_tim_pend, w_pending, w_take;
    logic [31:0]   w_cause_sel, w_vec;

    assign mip_meip     = r_ext_s2;
    assign mip_mtip     = r_tim_s2;
    assign w_ext_pend   = mip_meip & mie_meie;
    assign w_tim_pend   = mip_mtip & mie_mtie;
    assign w_pending    = w_ext_pend | w_tim_pend;
    assign w_take       = w_pending & mstatus_mie;
    assign w_cause_sel  = w_ext_pend ? CAUSE_EXT : CAUSE_TIM;
    assign w_vec        = mtvec & 32'hFFFF_FFFC;
    assign mepc_wdata   = r_resume_pc;
    assign mcause_wdata = r_cause;
    assign state_o      = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext_s1    <= 1'b0;
            r_ext_s2    <= 1'b0;
            r_tim_s1    <= 1'b0;
            r_tim_s2    <= 1'b0;
            r_state     <= S_RUN;
            r_cnt       <= '0;
            r_resume_pc <= RESET_PC;
            r_cause     <= '0;
        end else begin
            r_ext_s1    <= irq_ext;
            r_ext_s2    <= r_ext_s1;
            r_tim_s1    <= irq_timer;
            r_tim_s2    <= r_tim_s1;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_resume_pc <= w_resume_nxt;
            r_cause     <= w_cause_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_resume_nxt    = r_resume_pc;
        w_cause_nxt     = r_cause;
        interrupt_stall = 1'b0;
        flush           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = r_resume_pc;
        mepc_we         = 1'b0;
        mcause_we       = 1'b0;
        mstatus_trap    = 1'b0;
        mstatus_mret    = 1'b0;

        unique case (r_state)
            S_RUN: begin
                // MRET outranks a pending interrupt; the take is re-evaluated next cycle.
                if (wb_is_mret) begin
                    flush          = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = mepc_csr;
                    mstatus_mret   = 1'b1;
                end else if (w_take && id_valid && !dm_stall) begin
                    w_resume_nxt = id_pc;
                    w_cause_nxt  = w_cause_sel;
                    w_cnt_nxt    = CNT_INIT;
                    w_state_nxt  = S_DRAIN;
                end else if (id_is_wfi && id_valid && !dm_stall) begin
                    w_resume_nxt = id_pc + 32'd4;
                    w_state_nxt  = S_SLEEP;
                end
            end
            S_DRAIN: begin
                interrupt_stall = 1'b1;
                if (wb_is_mret) begin
                    mstatus_mret = 1'b1;
                    w_resume_nxt = mepc_csr;
                end
                if (!dm_stall) begin
                    if (r_cnt == CW'(1)) w_state_nxt = S_TRAP;
                    else                 w_cnt_nxt   = r_cnt - CW'(1);
                end
            end
            S_TRAP: begin
                mepc_we        = 1'b1;
                mcause_we      = 1'b1;
                mstatus_trap   = 1'b1;
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = w_vec;
                w_state_nxt    = S_RUN;
            end
            S_SLEEP: begin
                interrupt_stall = 1'b1;
                // Wake ignores the global enable; only the trap path honours it.
                if (w_pending) begin
                    if (mstatus_mie) begin
                        w_cause_nxt = w_cause_sel;
                        w_cnt_nxt   = CNT_INIT;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        flush          = 1'b1;
                        redirect_valid = 1'b1;
                        redirect_pc    = r_resume_pc;
                        w_state_nxt    = S_RUN;
                    end
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

endmodule

// File: doc/irq_trap_ctrl.md
Name: irq_trap_ctrl

Overview:
- Machine-mode interrupt/trap sequencer for the 5-stage RV32 core.
- Samples external and timer interrupt lines and freezes the pipeline through interrupt_stall while older instructions drain.
- Then performs the trap entry: writes mepc/mcause, updates mstatus and redirects fetch to mtvec.
- Also sequences MRET return and WFI sleep/wake. Sits beside the decode stage and CSR file.

Parameters:
- DRAIN_CYCLES, 3: cycles (counted only while dm_stall=0) needed to retire EX/MEM/WB before trap entry.
- RESET_PC, 32'h0: value of redirect_pc/mepc_wdata at reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- irq_ext  in  1  external interrupt, level, asynchronous
- irq_timer  in  1  timer interrupt, level, asynchronous
- mstatus_mie  in  1  global machine interrupt enable
- mie_meie  in  1  external interrupt enable
- mie_mtie  in  1  timer interrupt enable
- mtvec  in  32  trap vector CSR
- mepc_csr  in  32  current mepc CSR value
- id_valid  in  1  ID stage holds a real instruction
- id_pc  in  32  PC of the instruction in ID
- id_is_wfi  in  1  ID instruction is WFI
- wb_is_mret  in  1  MRET retiring in WB this cycle
- dm_stall  in  1  data-memory stall; pipeline frozen
- interrupt_stall  out  1  hold IF/ID/EX inputs; ID inserts no new instruction
- flush  out  1  one-cycle flush of IF/ID and ID/EX
- redirect_valid  out  1  load PC with redirect_pc next cycle
- redirect_pc  out  32  fetch redirect target
- mepc_we  out  1  write mepc
- mepc_wdata  out  32  resume PC
- mcause_we  out  1  write mcause
- mcause_wdata  out  32  trap cause
- mstatus_trap  out  1  pulse: MPIE<=MIE, MIE<=0
- mstatus_mret  out  1  pulse: MIE<=MPIE, MPIE<=1
- mip_meip  out  1  synchronized irq_ext
- mip_mtip  out  1  synchronized irq_timer
- state_o  out  2  current FSM state (debug)

Behaviour:
- Reset:
  - rst is asynchronous, active-high; clock is clk.
  - All outputs are 0, except redirect_pc=mepc_wdata=RESET_PC.
  - State is RUN; synchronizers, counter and latches are cleared.
  - Reset mid-operation aborts any DRAIN/TRAP/SLEEP with no CSR write.
- Synchronization: irq_ext and irq_timer each pass through a 2-flop synchronizer. mip_* are the synchronizer outputs, so interrupt latency is 2 cycles.
- Interrupt conditions:
  - pending = (mip_meip & mie_meie) | (mip_mtip & mie_mtie)
  - take = pending & mstatus_mie
- States: RUN=0, DRAIN=1, TRAP=2, SLEEP=3.
- RUN, evaluated in priority order:
  1. wb_is_mret: same cycle, assert flush=1, redirect_valid=1, redirect_pc=mepc_csr, mstatus_mret=1. Stay in RUN; take is ignored this cycle.
  2. take & id_valid & !dm_stall:
     - resume_pc<=id_pc.
     - Latch cause: external has priority, 32'h8000000B; else timer, 32'h80000007.
     - cnt<=DRAIN_CYCLES; go to DRAIN.
  3. id_is_wfi & id_valid & !dm_stall: resume_pc<=id_pc+4; go to SLEEP.
  - If none apply, remain in RUN.
- DRAIN:
  - interrupt_stall=1.
  - cnt decrements only when dm_stall=0; at cnt==1 with dm_stall=0, go to TRAP.
  - If wb_is_mret fires during DRAIN, pulse mstatus_mret and set resume_pc<=mepc_csr.
  - The cause latched at DRAIN entry is kept even if the interrupt deasserts.
- TRAP (exactly 1 cycle):
  - Pulse mepc_we and mcause_we; mepc_wdata=resume_pc, mcause_wdata=latched cause.
  - mstatus_trap=1, flush=1, redirect_valid=1, redirect_pc={mtvec[31:2],2'b00}, interrupt_stall=0.
  - Next state is RUN.
- SLEEP:
  - interrupt_stall=1.
  - Wakes when pending=1, regardless of mstatus_mie.
  - If take: latch cause, cnt<=DRAIN_CYCLES, go to DRAIN; resume_pc stays id_pc+4.
  - Else: one cycle of flush=1, redirect_valid=1, redirect_pc=resume_pc; go to RUN.
- Pulse rules: flush, redirect_valid, mepc_we, mcause_we, mstatus_trap and mstatus_mret are single-cycle, combinational from state/inputs. They are never asserted together except as listed above.
- PC arithmetic: id_pc+4 is modulo 2^32, so 32'hFFFFFFFC wraps to 0.

Test Plan:
- Timer trap:
  - Stimulus: mtvec=0x100, MIE=1, MTIE=1, id_pc=0x40, id_valid=1; raise irq_timer.
  - Response: stall begins 2 cycles later and lasts 3 cycles. Then one TRAP cycle with mepc_wdata=0x40, mcause_wdata=0x80000007, redirect_pc=0x100, flush=1.
- Both lines plus memory stall:
  - Stimulus: irq_ext and irq_timer raised together; dm_stall=1 for 4 cycles during DRAIN.
  - Response: mcause=0x8000000B; TRAP delayed by exactly 4 cycles.
- MRET:
  - Stimulus: wb_is_mret=1 with mepc_csr=0x2C.
  - Response: same cycle mstatus_mret=1, redirect_pc=0x2C, flush=1; a concurrent take starts DRAIN no earlier than the next cycle.
- WFI wake, masked:
  - Stimulus: WFI at id_pc=0x80, MIE=0; raise irq_ext after 10 cycles with MEIE=1.
  - Response: stall held throughout; then redirect_pc=0x84 with flush; no mepc_we.
- WFI wake, enabled:
  - Stimulus: same as previous with MIE=1.
  - Response: DRAIN, then TRAP with mepc_wdata=0x84, mcause=0x8000000B.
- Reset mid-DRAIN:
  - Stimulus: assert rst during DRAIN.
  - Response: all pulses 0, state_o=0, no mepc_we.
  - After release with irq low: no trap.
